sr_word_feeder: RTL

//  Upstream stage for the bidirectional shift register. Accepts parallel words

---
 rtl/sr_word_feeder.sv | 114 +++++++++++
 1 files changed

// File: rtl/sr_word_feeder.sv
// sr_word_feeder: serialises valid/ready words one bit per clock for a bidirectional shift register.
// Optional even-parity bit after each word when FEEDER_PARITY_EN is defined.
module sr_word_feeder #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             dir_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             shift_dir,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GLAST = 4'(GAP > 1 ? GAP - 2 : 0);
  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
`ifdef FEEDER_PARITY_EN
    PAR,
`endif
    DONE,
    GAPS
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic dir_q, dir_d;
  logic ser_out_q, ser_out_d;
  logic ready_q, busy_q, ser_en_q, done_q;
  // The DONE cycle is the first idle cycle after the frame, so GAPS covers the remaining GAP-1.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gcnt_d = gcnt_q;
    shreg_d = shreg_q;
    dir_d = dir_q;
    case (state_q)
      IDLE: if (word_valid && ready_q) begin
        state_d = SHIFT;
        shreg_d = word_in;
        dir_d = dir_in;
        cnt_d = '0;
      end
      SHIFT: if (cnt_q == LAST) begin
`ifdef FEEDER_PARITY_EN
        state_d = PAR;
`else
        state_d = DONE;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
        shreg_d = dir_q ? {shreg_q[0], shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      end
`ifdef FEEDER_PARITY_EN
      PAR: state_d = DONE;
`endif
      DONE: begin
        state_d = GAP > 1 ? GAPS : IDLE;
        gcnt_d = '0;
      end
      GAPS: if (gcnt_q == GLAST) state_d = IDLE; else gcnt_d = gcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // Rotation keeps every word bit in shreg, so its XOR is the frame parity.
    ser_out_d = (state_d == SHIFT) ? (dir_d ? shreg_d[0] : shreg_d[WIDTH-1]) :
`ifdef FEEDER_PARITY_EN
                (state_d == PAR) ? ^shreg_d :
`endif
                1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gcnt_q <= '0;
      shreg_q <= '0;
      dir_q <= 1'b0;
      ser_out_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      ser_en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
      shreg_q <= shreg_d;
      dir_q <= dir_d;
      ser_out_q <= ser_out_d;
      ready_q <= state_d == IDLE;
      busy_q <= state_d != IDLE;
`ifdef FEEDER_PARITY_EN
      ser_en_q <= state_d == SHIFT || state_d == PAR;
`else
      ser_en_q <= state_d == SHIFT;
`endif
      done_q <= state_d == DONE;
    end
  end
  assign word_ready = ready_q;
  assign ser_out = ser_out_q;
  assign ser_en = ser_en_q;
  assign shift_dir = dir_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule
